// File: rtl/bellek_hakemi_pkg.sv
// Shared types and constants for the bellek_hakemi memory arbiter.
package bellek_hakemi_pkg;

    // Default geometry of the shared data memory (veri_bellek)
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;

    // Port indices; also the encoding of the last-grant pointer and owner register
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Sequencer states: idle, read issued, response held
    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        OKU   = 2'd1,
        YANIT = 2'd2
    } durum_t;

endpackage

// File: rtl/bellek_hakemi_rr_secici.sv
// 2-way round-robin grant picker. grant[0] selects port A, grant[1] port B.
// On a tie the port that was not granted last wins.
module rr_secici
    import bellek_hakemi_pkg::*;
(
    input  logic       a_valid,
    input  logic       b_valid,
    input  logic       son_port,
    output logic [1:0] grant
);

    // One-hot grant from the two request bits and the last-grant pointer
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        grant = 2'b00;
        if (a_valid && b_valid) begin
            grant = (son_port == PORT_A) ? 2'b10 : 2'b01;
        end else if (a_valid) begin
            grant = 2'b01;
        end else if (b_valid) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/bellek_hakemi.sv
// bellek_hakemi: arbiter and sequencer for the single-port data memory shared by
// port A (core load/store) and port B (loader / debug master).
// Define BELLEK_HAKEMI_SABIT_ONCELIK_EN for fixed priority (A always wins ties);
// the default build arbitrates round-robin.
module bellek_hakemi
    import bellek_hakemi_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rsp_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    durum_t            durum, durum_next;
    logic              sahip;        // port that owns the read in flight
    logic              secici_ptr;   // pointer seen by the picker
    logic [1:0]        grant;
    logic              secilen_we;
    logic [DATA_W-1:0] a_tampon, b_tampon;

    rr_secici u_secici (
        .a_valid  (a_req_valid),
        .b_valid  (b_req_valid),
        .son_port (secici_ptr),
        .grant    (grant)
    );

    assign secilen_we  = grant[1] ? b_req_we : a_req_we;
    assign a_rsp_rdata = a_tampon;
    assign b_rsp_rdata = b_tampon;

`ifdef BELLEK_HAKEMI_SABIT_ONCELIK_EN
    // Fixed priority: a constant "B was last" pointer makes A win every tie
    assign secici_ptr = PORT_B;
`else
    logic son_port;

    // Last-grant pointer, advanced on every accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            son_port <= PORT_B;
        end else if (mem_en) begin
            son_port <= grant[1];
        end
    end

    assign secici_ptr = son_port;
`endif

    // State register and read-owner capture
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            durum <= BOSTA;
            sahip <= PORT_A;
        end else begin
            durum <= durum_next;
            if (durum == BOSTA && mem_en && !mem_we) begin
                sahip <= grant[1];
            end
        end
    end

    // Response buffers: memory read data lands in the owner's buffer during OKU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_tampon <= '0;
            b_tampon <= '0;
        end else if (durum == OKU) begin
            if (sahip == PORT_A) begin
                a_tampon <= mem_rdata;
            end else begin
                b_tampon <= mem_rdata;
            end
        end
    end

    // Next state, handshakes and memory strobes; reset gates every strobe immediately
    always_comb begin
        durum_next  = durum;
        a_req_ready = 1'b0;
        b_req_ready = 1'b0;
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        unique case (durum)
            BOSTA: begin
                if (!rst && (grant != 2'b00)) begin
                    a_req_ready = grant[0];
                    b_req_ready = grant[1];
                    mem_en      = 1'b1;
                    mem_we      = secilen_we;
                    mem_addr    = grant[1] ? b_req_addr  : a_req_addr;
                    mem_wdata   = grant[1] ? b_req_wdata : a_req_wdata;
                    if (!secilen_we) begin
                        durum_next = OKU;
                    end
                end
            end
            OKU: begin
                durum_next = YANIT;
            end
            YANIT: begin
                a_rsp_valid = !rst && (sahip == PORT_A);
                b_rsp_valid = !rst && (sahip == PORT_B);
                if ((sahip == PORT_A) ? a_rsp_ready : b_rsp_ready) begin
                    durum_next = BOSTA;
                end
            end
            default: begin
                durum_next = BOSTA;
            end
        endcase
    end

endmodule
